// File: rtl/multichannel_audio_parallelizer.sv
// multichannel_audio_parallelizer: packs channel-tagged serial samples into double-buffered parallel frames.
// Define MCAP_DROP_COUNTER_EN to add the saturating o_drop_count output.
module multichannel_audio_parallelizer #(
  parameter int audio_width = 32,
  parameter int channels = 2,
  localparam int channel_bits = channels > 1 ? $clog2(channels) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_valid,
  output logic                            i_ready,
  input  logic [channel_bits-1:0]         i_channel,
  input  logic [audio_width-1:0]          i_audio,
  output logic                            o_valid,
  input  logic                            o_ready,
  output logic [channels*audio_width-1:0] o_audio,
  output logic                            o_sync_error
`ifdef MCAP_DROP_COUNTER_EN
  ,
  output logic [15:0]                     o_drop_count
`endif
);
  logic [channel_bits-1:0] ch_idx;
  logic pending;
  logic [channels*audio_width-1:0] asm_buf, merged;
  logic acc, out_xfer, in_order, last, complete;
  assign i_ready = !pending;
  assign acc = i_valid && i_ready;
  assign out_xfer = o_valid && o_ready;
  assign in_order = i_channel == ch_idx;
  assign last = ch_idx == channel_bits'(channels - 1);
  assign complete = acc && in_order && last;
  always_comb begin
    merged = asm_buf;
    merged[ch_idx*audio_width +: audio_width] = i_audio;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_idx <= '0;
      pending <= 1'b0;
      asm_buf <= '0;
      o_audio <= '0;
      o_valid <= 1'b0;
      o_sync_error <= 1'b0;
    end else begin
      o_sync_error <= acc && !in_order;
      if (acc) begin
        if (in_order) begin
          asm_buf <= merged;
          ch_idx <= last ? '0 : ch_idx + 1'b1;
        end else if (i_channel == '0) begin
          asm_buf[audio_width-1:0] <= i_audio;
          ch_idx <= channel_bits'(1);
        end else
          ch_idx <= '0;
      end
      // a pending frame always drains before anything new can complete
      if (pending && out_xfer) begin
        o_audio <= asm_buf;
        pending <= 1'b0;
      end else if (complete && (!o_valid || out_xfer)) begin
        o_audio <= merged;
        o_valid <= 1'b1;
      end else if (complete)
        pending <= 1'b1;
      else if (out_xfer)
        o_valid <= 1'b0;
    end
  end
`ifdef MCAP_DROP_COUNTER_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      o_drop_count <= '0;
    else if (o_sync_error && o_drop_count != 16'hFFFF)
      o_drop_count <= o_drop_count + 1'b1;
  end
`endif
endmodule

// File: tb/tb_multichannel_audio_parallelizer.sv
// tb_multichannel_audio_parallelizer: directed table plus hand sequences over 2-, 3- and 4-channel instances.
module tb_multichannel_audio_parallelizer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  int checks = 0;
  int fails = 0;
  logic v2 = 0, r2 = 0, ir2, ov2, se2;
  logic [0:0] c2 = '0;
  logic [31:0] a2 = '0;
  logic [63:0] oa2;
  logic v3 = 0, r3 = 0, ir3, ov3, se3;
  logic [1:0] c3 = '0;
  logic [31:0] a3 = '0;
  logic [95:0] oa3;
  logic v4 = 0, r4 = 0, ir4, ov4, se4;
  logic [1:0] c4 = '0;
  logic [31:0] a4 = '0;
  logic [127:0] oa4;
`ifdef MCAP_DROP_COUNTER_EN
  logic [15:0] dc2, dc3, dc4;
`endif
  multichannel_audio_parallelizer #(.audio_width(32), .channels(2)) u2 (
    .clk(clk), .reset(reset), .i_valid(v2), .i_ready(ir2), .i_channel(c2), .i_audio(a2),
    .o_valid(ov2), .o_ready(r2), .o_audio(oa2), .o_sync_error(se2)
`ifdef MCAP_DROP_COUNTER_EN
    , .o_drop_count(dc2)
`endif
  );
  multichannel_audio_parallelizer #(.audio_width(32), .channels(3)) u3 (
    .clk(clk), .reset(reset), .i_valid(v3), .i_ready(ir3), .i_channel(c3), .i_audio(a3),
    .o_valid(ov3), .o_ready(r3), .o_audio(oa3), .o_sync_error(se3)
`ifdef MCAP_DROP_COUNTER_EN
    , .o_drop_count(dc3)
`endif
  );
  multichannel_audio_parallelizer #(.audio_width(32), .channels(4)) u4 (
    .clk(clk), .reset(reset), .i_valid(v4), .i_ready(ir4), .i_channel(c4), .i_audio(a4),
    .o_valid(ov4), .o_ready(r4), .o_audio(oa4), .o_sync_error(se4)
`ifdef MCAP_DROP_COUNTER_EN
    , .o_drop_count(dc4)
`endif
  );
  typedef struct {
    logic v;
    logic [1:0] ch;
    logic [31:0] a;
    logic rdy;
    logic ov;
    logic ir;
    logic se;
    logic [127:0] oa;
  } vec_t;
  vec_t tbl [25];
  localparam logic [127:0] FA = {32'd4, 32'd3, 32'd2, 32'd1};
  localparam logic [127:0] FB = {32'd8, 32'd7, 32'd6, 32'd5};
  localparam logic [127:0] FC = {32'hB3, 32'hB2, 32'hB1, 32'hAA};
  localparam logic [127:0] FD = {32'h33, 32'h32, 32'h31, 32'h30};
  localparam logic [127:0] FE = {32'h43, 32'h42, 32'h41, 32'h40};
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic send4(input logic [1:0] ch, input logic [31:0] a);
    v4 = 1'b1; c4 = ch; a4 = a;
    @(negedge clk);
  endtask
  initial begin
    tbl[0]  = '{1'b1, 2'd0, 32'h1,  1'b0, 1'b0, 1'b1, 1'b0, '0};
    tbl[1]  = '{1'b1, 2'd1, 32'h2,  1'b0, 1'b0, 1'b1, 1'b0, '0};
    tbl[2]  = '{1'b1, 2'd2, 32'h3,  1'b0, 1'b0, 1'b1, 1'b0, '0};
    tbl[3]  = '{1'b1, 2'd3, 32'h4,  1'b0, 1'b1, 1'b1, 1'b0, FA};
    tbl[4]  = '{1'b1, 2'd0, 32'h5,  1'b0, 1'b1, 1'b1, 1'b0, FA};
    tbl[5]  = '{1'b1, 2'd1, 32'h6,  1'b0, 1'b1, 1'b1, 1'b0, FA};
    tbl[6]  = '{1'b1, 2'd2, 32'h7,  1'b0, 1'b1, 1'b1, 1'b0, FA};
    tbl[7]  = '{1'b1, 2'd3, 32'h8,  1'b0, 1'b1, 1'b0, 1'b0, FA};
    tbl[8]  = '{1'b1, 2'd0, 32'h9,  1'b0, 1'b1, 1'b0, 1'b0, FA};
    tbl[9]  = '{1'b0, 2'd0, 32'h0,  1'b1, 1'b1, 1'b1, 1'b0, FB};
    tbl[10] = '{1'b0, 2'd0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, FB};
    tbl[11] = '{1'b0, 2'd0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, FB};
    tbl[12] = '{1'b1, 2'd0, 32'h10, 1'b1, 1'b0, 1'b1, 1'b0, FB};
    tbl[13] = '{1'b1, 2'd1, 32'h11, 1'b1, 1'b0, 1'b1, 1'b0, FB};
    tbl[14] = '{1'b1, 2'd0, 32'hAA, 1'b1, 1'b0, 1'b1, 1'b1, FB};
    tbl[15] = '{1'b1, 2'd1, 32'hB1, 1'b1, 1'b0, 1'b1, 1'b0, FB};
    tbl[16] = '{1'b1, 2'd2, 32'hB2, 1'b1, 1'b0, 1'b1, 1'b0, FB};
    tbl[17] = '{1'b1, 2'd3, 32'hB3, 1'b1, 1'b1, 1'b1, 1'b0, FC};
    tbl[18] = '{1'b1, 2'd0, 32'h20, 1'b1, 1'b0, 1'b1, 1'b0, FC};
    tbl[19] = '{1'b1, 2'd2, 32'h22, 1'b1, 1'b0, 1'b1, 1'b1, FC};
    tbl[20] = '{1'b1, 2'd0, 32'h30, 1'b1, 1'b0, 1'b1, 1'b0, FC};
    tbl[21] = '{1'b1, 2'd1, 32'h31, 1'b1, 1'b0, 1'b1, 1'b0, FC};
    tbl[22] = '{1'b1, 2'd2, 32'h32, 1'b1, 1'b0, 1'b1, 1'b0, FC};
    tbl[23] = '{1'b1, 2'd3, 32'h33, 1'b1, 1'b1, 1'b1, 1'b0, FD};
    tbl[24] = '{1'b0, 2'd0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, FD};
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset o_valid", ov4, 0);
    check("reset i_ready", ir4, 1);
    check("reset o_audio", oa4, 0);
    check("reset o_sync_error", se4, 0);
`ifdef MCAP_DROP_COUNTER_EN
    check("reset drop_count", dc4, 0);
`endif
    // two-channel back-to-back frame, consumer always ready
    r2 = 1'b1; v2 = 1'b1; c2 = 1'b0; a2 = 32'h11111111;
    @(negedge clk);
    check("c2 ch0 o_valid", ov2, 0);
    check("c2 ch0 sync", se2, 0);
    c2 = 1'b1; a2 = 32'h22222222;
    @(negedge clk);
    check("c2 frame o_valid", ov2, 1);
    check("c2 frame o_audio", oa2, 64'h22222222_11111111);
    check("c2 frame sync", se2, 0);
    v2 = 1'b0;
    @(negedge clk);
    check("c2 drained o_valid", ov2, 0);
    check("c2 drained sync", se2, 0);
    // four-channel table
    for (int i = 0; i < 25; i++) begin
      v4 = tbl[i].v; c4 = tbl[i].ch; a4 = tbl[i].a; r4 = tbl[i].rdy;
      @(negedge clk);
      check($sformatf("tbl[%0d] o_valid", i), ov4, tbl[i].ov);
      check($sformatf("tbl[%0d] i_ready", i), ir4, tbl[i].ir);
      check($sformatf("tbl[%0d] o_sync_error", i), se4, tbl[i].se);
      check($sformatf("tbl[%0d] o_audio", i), oa4, tbl[i].oa);
    end
    v4 = 1'b0; r4 = 1'b0;
`ifdef MCAP_DROP_COUNTER_EN
    check("c4 drop_count", dc4, 2);
`endif
    // three-channel: out-of-range index, then a clean frame
    r3 = 1'b1; v3 = 1'b1; c3 = 2'd3; a3 = 32'hDEAD;
    @(negedge clk);
    check("c3 range sync", se3, 1);
    check("c3 range o_valid", ov3, 0);
    c3 = 2'd0; a3 = 32'hC0;
    @(negedge clk);
    check("c3 ch0 sync", se3, 0);
    c3 = 2'd1; a3 = 32'hC1;
    @(negedge clk);
    c3 = 2'd2; a3 = 32'hC2;
    @(negedge clk);
    check("c3 frame o_valid", ov3, 1);
    check("c3 frame o_audio", oa3, 96'h000000C2_000000C1_000000C0);
    v3 = 1'b0;
`ifdef MCAP_DROP_COUNTER_EN
    @(negedge clk);
    check("c3 drop_count", dc3, 1);
`endif
    // reset while a frame is pending and the output is held
    r4 = 1'b0;
    for (int i = 0; i < 8; i++) send4(2'(i % 4), 32'(i + 1));
    v4 = 1'b0;
    check("pend i_ready", ir4, 0);
    check("pend o_valid", ov4, 1);
    check("pend o_audio", oa4, FA);
    #2 reset = 1'b1;
    #1;
    check("async rst o_valid", ov4, 0);
    check("async rst i_ready", ir4, 1);
    check("async rst o_audio", oa4, 0);
    @(negedge clk);
    reset = 1'b0;
    r4 = 1'b1;
    for (int i = 0; i < 4; i++) send4(2'(i), 32'h40 + 32'(i));
    v4 = 1'b0;
    check("post rst o_valid", ov4, 1);
    check("post rst o_audio", oa4, FE);
    check("post rst sync", se4, 0);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
